// File: rtl/microc_stack.sv
// microc_stack: single-cycle microcontroller datapath with a hardware call/return stack
// Ports: clk/reset (sync, active-high)/en (stall); imem_addr/imem_data instruction fetch;
// Opcode to control unit; s_inc/s_inm/we/wez/ALUOp/push/pop control strobes;
// zero (registered), alu_y (combinational), sp_count, sticky stack_ovf/stack_unf.
module microc_stack #(
  parameter int DATA_W      = 8,
  parameter int PC_W        = 10,
  parameter int STACK_DEPTH = 4,
  parameter int SP_W        = $clog2(STACK_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [15:0]       imem_data,
  output logic [5:0]        Opcode,
  input  logic              s_inc,
  input  logic              s_inm,
  input  logic              we,
  input  logic              wez,
  input  logic [2:0]        ALUOp,
  input  logic              push,
  input  logic              pop,
  output logic              zero,
  output logic [DATA_W-1:0] alu_y,
  output logic [SP_W-1:0]   sp_count,
  output logic              stack_ovf,
  output logic              stack_unf
);
  localparam logic [SP_W-1:0] FULL = SP_W'(STACK_DEPTH);
  // sized to the full sp index range so sp_q can index it directly; entries past FULL are never written
  logic [PC_W-1:0]   stack_q [2**SP_W];
  logic [DATA_W-1:0] rf_q [16];
  logic [PC_W-1:0]   pc_q, pc_d, pc_inc;
  logic [SP_W-1:0]   sp_q, sp_d;
  logic [DATA_W-1:0] rd1, rd2, wd;
  logic              zero_q, ovf_q, unf_q, do_pop, do_push;
  assign imem_addr = pc_q;
  assign Opcode    = imem_data[15:10];
  assign zero      = zero_q;
  assign sp_count  = sp_q;
  assign stack_ovf = ovf_q;
  assign stack_unf = unf_q;
  always_comb begin
    rd1 = rf_q[imem_data[11:8]];
    rd2 = rf_q[imem_data[7:4]];
    alu_y = rd1;
    case (ALUOp)
      3'b001:  alu_y = ~rd1;
      3'b010:  alu_y = rd1 + rd2;
      3'b011:  alu_y = rd1 - rd2;
      3'b100:  alu_y = rd1 & rd2;
      3'b101:  alu_y = rd1 | rd2;
      3'b110:  alu_y = -rd1;
      3'b111:  alu_y = -rd2;
      default: alu_y = rd1;
    endcase
    wd = s_inm ? DATA_W'(imem_data[11:4]) : alu_y;
    pc_inc = pc_q + PC_W'(1);
    do_pop = pop && sp_q != '0;
    do_push = push && !pop && sp_q != FULL;
    // an underflowing pop still falls through to PC+1 rather than the jump target
    pc_d = do_pop ? stack_q[sp_q - SP_W'(1)] : (pop || s_inc) ? pc_inc : imem_data[PC_W-1:0];
    sp_d = do_pop ? sp_q - SP_W'(1) : do_push ? sp_q + SP_W'(1) : sp_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q   <= '0;
      sp_q   <= '0;
      zero_q <= 1'b0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
      for (int i = 0; i < 16; i++) rf_q[i] <= '0;
    end else if (en) begin
      pc_q <= pc_d;
      sp_q <= sp_d;
      if (wez) zero_q <= alu_y == '0;
      // R0 is never written, so its reset value keeps it reading as zero
      if (we && imem_data[3:0] != 4'd0) rf_q[imem_data[3:0]] <= wd;
      if (pop && sp_q == '0) unf_q <= 1'b1;
      if (push && !pop && sp_q == FULL) ovf_q <= 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (en && do_push) stack_q[sp_q] <= pc_inc;
  end
endmodule

// File: doc/microc_stack.md
# microc_stack

Parametrised single-cycle microcontroller datapath with a hardware call/return stack. It fetches one instruction per cycle from an external instruction memory and executes register-file/ALU operations under the existing external control unit's strobes. It adds subroutine call (push) and return (pop) with overflow/underflow detection, a datapath-wide enable for stalling, and configurable data, PC and stack widths. It replaces the fixed-width datapath as the core of the processor top level.

## Interface
- DATA_W, 8: register/ALU width; must be ≥ 8.
- PC_W, 10: program counter width; must be ≤ 10.
- STACK_DEPTH, 4: return-address entries; must be ≥ 1.
- SP_W, $clog2(STACK_DEPTH+1): width of sp_count.

- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- en  in  1  advance enable; low freezes all state.
- imem_addr  out  PC_W  current PC, to the instruction memory.
- imem_data  in  16  instruction at imem_addr; combinational memory.
- Opcode  out  6  imem_data[15:10], to the control unit.
- s_inc  in  1  1: next PC = PC+1; 0: next PC = jump target imem_data[PC_W-1:0].
- s_inm  in  1  1: write data = immediate; 0: write data = ALU result.
- we  in  1  register-file write enable.
- wez  in  1  zero-flag update enable.
- ALUOp  in  3  ALU operation.
- push  in  1  call: push PC+1 onto the stack.
- pop  in  1  return: next PC = top of stack.
- zero  out  1  registered zero flag.
- alu_y  out  DATA_W  combinational ALU result.
- sp_count  out  SP_W  current stack occupancy.
- stack_ovf  out  1  sticky overflow flag.
- stack_unf  out  1  sticky underflow flag.

## Operation
- Instruction fields overlap and are decoded by the control unit:
  - RA1 = [11:8], RA2 = [7:4], WA3 = [3:0].
  - Inm = [11:4], zero-extended to DATA_W.
  - Jump target = [PC_W-1:0].
- Register file:
  - 16 × DATA_W, two combinational read ports (RD1 ← RA1, RD2 ← RA2), one synchronous write port.
  - R0 always reads 0; writes to R0 are ignored.
  - No read bypass: a write becomes visible the cycle after it.
- ALU (A = RD1, B = RD2), results modulo 2^DATA_W:
  - 000 A; 001 ~A; 010 A+B; 011 A−B; 100 A&B; 101 A|B; 110 −A; 111 −B.
- Register write: when en & we, WA3 ← (s_inm ? Inm : alu_y).
- Zero flag: when en & wez, zero ← (alu_y == 0); otherwise it holds. The flag reflects the ALU result even when s_inm = 1.
- Next PC, in priority order (only when en = 1):
  - pop & sp_count > 0 → PC ← top of stack; sp_count decrements.
  - pop & sp_count == 0 → PC ← PC+1; stack_unf ← 1.
  - otherwise → PC ← s_inc ? PC+1 : jump target.
- Push (only when pop = 0 and en = 1):
  - sp_count < STACK_DEPTH → stack[sp_count] ← PC+1; sp_count increments.
  - stack full → stack unchanged; stack_ovf ← 1. The PC still follows s_inc.
- push & pop in the same cycle: pop wins and push is ignored (no flag).
- PC+1 wraps modulo 2^PC_W, both for the PC and for the pushed address.
- stack_ovf and stack_unf clear only on reset.

## Timing
- All state updates on the rising clk edge; reset has priority over en.
- Reset values:
  - PC / imem_addr = 0.
  - Registers R1..R15 = 0.
  - zero = 0, sp_count = 0, stack_ovf = 0, stack_unf = 0.
  - Stack contents are don't-care.
- Reset asserted mid-call discards all return addresses.
- Opcode and alu_y are combinational from imem_data and the current register contents. There is no registered output latency besides zero.
- Single cycle per instruction: control inputs sampled at edge N take effect in the state visible after edge N.
- en = 0: PC, registers, zero, stack, sp_count and flags all hold; combinational outputs still track the inputs.

## Test plan
- Reset: reset = 1 for 2 cycles, then 0 → imem_addr = 0, zero = 0, sp_count = 0, stack_ovf = 0, stack_unf = 0; reading R0..R15 via ALUOp 000 gives 0.
- Immediate and ALU:
  - Load Inm = 0x05 → R1, then Inm = 0x03 → R2 (s_inm = 1, we = 1).
  - ALUOp 010, RA1 = 1, RA2 = 2, WA3 = 3, wez = 1 → alu_y = 0x08, zero = 0, R3 = 8.
  - ALUOp 011, RA1 = RA2 = 1, wez = 1 → zero = 1.
  - ALUOp 110 on R1 → alu_y = 0xFB.
- Call/return: at PC = 0x004, push = 1, s_inc = 0, target 0x020 → PC = 0x020, sp_count = 1; pop = 1 → PC = 0x005, sp_count = 0.
- Overflow (STACK_DEPTH = 4):
  - Five nested calls from PCs 0x10, 0x20, 0x30, 0x40, 0x50 → sp_count = 4, stack_ovf = 1; the fifth jump is still taken.
  - Four pops then return to 0x41, 0x31, 0x21, 0x11.
- Underflow and conflict:
  - pop on an empty stack at PC = 0x007 → PC = 0x008, stack_unf = 1, and it stays set.
  - push & pop together with sp_count = 1 → pop only; sp_count = 0, stack_ovf unchanged.
- Stall and wrap:
  - en = 0 for 3 cycles with we/push asserted → no state change.
  - PC = 0x3FF, s_inc = 1 → PC = 0x000.
  - Reset during a call with sp_count = 2 → sp_count = 0.
